// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and helpers for the configurable UART transmitter
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // The reserved encoding behaves exactly like "no parity".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode != PAR_NONE) && (mode != PAR_RSVD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - register-based synchronous FIFO with a registered read-data output
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rdata   = rdata_q;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      rdata_d  = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - FIFO-buffered UART transmitter with runtime divisor, parity and stop-bit selection
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              tx_clk,
  input  logic              tx_reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        pmode_q, pmode_d;
  logic              stop2_q, stop2_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic [DIV_W-1:0]  div_clamped;
  logic              bit_end, launch, par_next;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (tx_clk),
    .rst_n (tx_reset),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign s_ready     = !fifo_full;
  assign busy        = (state_q != IDLE);
  assign tx          = tx_q;
  assign div_clamped = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
  assign bit_end     = (cnt_q == div_q - DIV_W'(1));
  assign par_next    = par_q ^ shift_q[0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + DIV_W'(1);
    div_d      = div_q;
    pmode_d    = pmode_q;
    stop2_d    = stop2_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    tx_d       = tx_q;
    launch     = 1'b0;
    tx_done    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty) launch = 1'b1;
      end
      START: begin
        // The popped word sits in the FIFO read register until the start bit ends.
        if (bit_end) begin
          state_d = DATA;
          shift_d = fifo_rdata;
          tx_d    = fifo_rdata[0];
          idx_d   = '0;
          par_d   = 1'b0;
        end
      end
      DATA: begin
        if (bit_end) begin
          par_d = par_next;
          if (idx_q == LAST_IDX) begin
            if (parity_enabled(pmode_q)) begin
              state_d = PARITY;
              tx_d    = (pmode_q == PAR_ODD) ? ~par_next : par_next;
            end else begin
              state_d    = STOP;
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            tx_done = 1'b1;
            if (!fifo_empty) launch = 1'b1;
            else             state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: configuration is sampled only here, so mid-frame changes wait.
    if (launch) begin
      state_d = START;
      cnt_d   = '0;
      div_d   = div_clamped;
      pmode_d = parity_mode;
      stop2_d = stop2;
      tx_d    = 1'b0;
    end
  end

  assign fifo_pop = launch;

  always_ff @(posedge tx_clk or negedge tx_reset) begin
    if (!tx_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_W'(MIN_DIV);
      pmode_q    <= PAR_NONE;
      stop2_q    <= 1'b0;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pmode_q    <= pmode_d;
      stop2_q    <= stop2_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed, table-driven bench for uart_tx_cfg
module tb_uart_tx_cfg;

  logic        tx_clk = 1'b0;
  logic        tx_reset;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        tx;
  logic        busy;
  logic        tx_done;
  logic [2:0]  fifo_level;

  always #5 tx_clk = ~tx_clk;

  uart_tx_cfg #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .tx_clk      (tx_clk),
    .tx_reset    (tx_reset),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done),
    .fifo_level  (fifo_level)
  );

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pmode;
    logic        stop2;
    logic [15:0] div;
    int          p;
    string       bits;
  } vec_t;

  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;

  logic log_en = 1'b0;
  int   log_n  = 0;
  logic log_tx   [128];
  logic log_busy [128];
  logic log_done [128];

  always @(negedge tx_clk) begin
    if (log_en && log_n < 128) begin
      log_tx[log_n]   = tx;
      log_busy[log_n] = busy;
      log_done[log_n] = tx_done;
      log_n           = log_n + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int len, bad, done_n, done_at;
    logic exp_bit;
    baud_div    = v.div;
    parity_mode = v.pmode;
    stop2       = v.stop2;
    s_data      = v.data;
    s_valid     = 1'b1;
    check({tag, "_ready"}, 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    check({tag, "_level"}, 32'(fifo_level), 32'd1);
    check({tag, "_latency"}, 32'(tx), 32'd1);
    len     = v.bits.len() * v.p;
    bad     = 0;
    done_n  = 0;
    done_at = -1;
    for (int c = 0; c < len; c++) begin
      step();
      exp_bit = (v.bits[c / v.p] == "1");
      if (tx !== exp_bit || busy !== 1'b1) bad++;
      if (tx_done === 1'b1) begin
        done_n++;
        done_at = c;
      end
      if (c == 0) begin
        baud_div    = 16'd5;
        parity_mode = v.pmode ^ 2'b01;
        stop2       = ~v.stop2;
      end
    end
    check({tag, "_bits"}, 32'(bad), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_n), 32'd1);
    check({tag, "_done_at"}, 32'(done_at), 32'(len - 1));
    step();
    check({tag, "_idle"}, {29'd0, tx, busy, tx_done}, 32'b100);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] words [6];
    int n, guard, bad_tx, bad_busy, bad_done, k, b;
    logic rdy, e_tx, e_busy, e_done;

    vecs[0] = '{8'hA5, 2'b00, 1'b0, 16'd4, 4, "0101001011"};
    vecs[1] = '{8'hA5, 2'b01, 1'b0, 16'd4, 4, "01010010101"};
    vecs[2] = '{8'hA5, 2'b10, 1'b0, 16'd4, 4, "01010010111"};
    vecs[3] = '{8'h07, 2'b01, 1'b0, 16'd4, 4, "01110000011"};
    vecs[4] = '{8'h00, 2'b00, 1'b1, 16'd0, 2, "00000000011"};
    vecs[5] = '{8'hFF, 2'b10, 1'b0, 16'd1, 2, "01111111111"};
    vecs[6] = '{8'h3C, 2'b11, 1'b1, 16'd3, 3, "00011110011"};

    tx_reset    = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    baud_div    = 16'd4;
    parity_mode = 2'b00;
    stop2       = 1'b0;

    // Reset defaults: {tx, busy, tx_done, s_ready, fifo_level}
    repeat (3) step();
    check("reset_hold", {25'd0, tx, busy, tx_done, s_ready, fifo_level}, 32'b1001000);
    tx_reset = 1'b1;
    step();
    check("reset_release", {25'd0, tx, busy, tx_done, s_ready, fifo_level}, 32'b1001000);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during DATA bit 3 of 0xA5 with a second word queued behind it.
    baud_div    = 16'd4;
    parity_mode = 2'b00;
    stop2       = 1'b0;
    s_data      = 8'hA5;
    s_valid     = 1'b1;
    step();
    s_data = 8'h3C;
    step();
    s_valid = 1'b0;
    repeat (17) step();
    check("midrst_before", {29'd0, tx, busy, fifo_level == 3'd1}, 32'b011);
    #2;
    tx_reset = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_state", {27'd0, busy, s_ready, fifo_level}, 32'b01000);
    step();
    step();
    tx_reset = 1'b1;
    step();
    check("midrst_quiet", {30'd0, tx, busy}, 32'b10);
    run_vec(vecs[0], "post_rst");

    // Backpressure: six words offered continuously, P=2, no parity, one stop bit.
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    baud_div    = 16'd2;
    parity_mode = 2'b00;
    stop2       = 1'b0;
    log_en      = 1'b1;
    n           = 0;
    guard       = 0;
    s_data      = words[0];
    s_valid     = 1'b1;
    while (n < 5 && guard < 20) begin
      rdy = s_ready;
      step();
      if (rdy) n++;
      s_data = words[n];
      guard++;
    end
    check("bp_accepted", 32'(n), 32'd5);
    check("bp_full", {28'd0, s_ready, fifo_level}, 32'b0100);
    step();
    check("bp_blocked", 32'(fifo_level), 32'd4);
    s_valid = 1'b0;
    guard   = 0;
    while (log_n < 110 && guard < 300) begin
      step();
      guard++;
    end
    log_en = 1'b0;
    check("bp_log_len", 32'(log_n >= 110), 32'd1);

    bad_tx   = 0;
    bad_busy = 0;
    bad_done = 0;
    for (int i = 0; i < 110; i++) begin
      if (i < 2 || i >= 102) begin
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
      end else begin
        k      = i - 2;
        b      = (k % 20) / 2;
        e_busy = 1'b1;
        e_done = ((k % 20) == 19);
        if (b == 0)      e_tx = 1'b0;
        else if (b <= 8) e_tx = words[k / 20][b - 1];
        else             e_tx = 1'b1;
      end
      if (log_tx[i] !== e_tx)     bad_tx++;
      if (log_busy[i] !== e_busy) bad_busy++;
      if (log_done[i] !== e_done) bad_done++;
    end
    check("bp_stream_tx", 32'(bad_tx), 32'd0);
    check("bp_stream_busy", 32'(bad_busy), 32'd0);
    check("bp_stream_done", 32'(bad_done), 32'd0);
    check("bp_drained", 32'(fifo_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
